// File: rtl/gol_pkg.sv
// Shared types and default parameters for the Game-of-Life generation scheduler.
package gol_pkg;

  // Default number of displayed frames per generation in run mode (1..255).
  localparam int FRAMES_PER_GEN_DEF = 8;

  // Default width of the completed-generation counter.
  localparam int GEN_W_DEF = 16;

  // Scheduler states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VB = 3'd1,
    ST_START   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_SWAP    = 3'd4
  } gol_sched_state_t;

endpackage

// File: rtl/gol_frame_divider.sv
// Frame divider: counts frame_start pulses while run is high and emits a
// one-cycle gen_due pulse on every FRAMES_PER_GEN-th frame.
module gol_frame_divider
  import gol_pkg::*;
#(
  parameter int FRAMES_PER_GEN = FRAMES_PER_GEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic frame_start,
  output logic gen_due
);

  // Eight bits covers the full 1..255 range of FRAMES_PER_GEN.
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count and due pulse; stopping run parks the count at zero.
  always_comb begin
    count_d = count_q;
    gen_due = 1'b0;
    if (!run) begin
      count_d = 8'd0;
    end else if (frame_start) begin
      if (count_q == LAST_FRAME) begin
        count_d = 8'd0;
        gen_due = 1'b1;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  // Frame count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Generation scheduler: decides when the update engine runs, launches it in
// vertical blanking, arbitrates the shared cell-RAM read port (display first),
// flips the double buffer and counts completed generations.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | nothing to do; waits for a pending generation request
// ST_WAIT_VB | request accepted; waits for vertical blanking
// ST_START   | one-cycle eng_start pulse; pending request consumed
// ST_COMPUTE | engine running; waits for eng_done
// ST_SWAP    | one-cycle swap pulse; buffer flips on exit
module gol_gen_scheduler
  import gol_pkg::*;
#(
  parameter int FRAMES_PER_GEN = FRAMES_PER_GEN_DEF,
  parameter int GEN_W          = GEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             frame_start,
  input  logic             vblank,
  input  logic             disp_req,
  output logic             disp_grant,
  output logic             eng_start,
  output logic             eng_grant,
  input  logic             eng_done,
  output logic             swap,
  output logic             buf_sel,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             err_overrun
);

  gol_sched_state_t state_q;
  gol_sched_state_t state_d;

  logic             pending_q;
  logic             pending_d;
  logic             step_q;
  logic             step_d;
  logic             buf_sel_q;
  logic             buf_sel_d;
  logic [GEN_W-1:0] gen_count_q;
  logic [GEN_W-1:0] gen_count_d;
  logic             err_overrun_q;
  logic             err_overrun_d;

  logic             gen_due;
  logic             step_rise;

  gol_frame_divider #(
    .FRAMES_PER_GEN (FRAMES_PER_GEN)
  ) u_frame_divider (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .frame_start (frame_start),
    .gen_due     (gen_due)
  );

  // Next state and the one-cycle strobes tied to START and SWAP.
  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    swap      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) state_d = ST_WAIT_VB;
      end
      ST_WAIT_VB: begin
        if (vblank) state_d = ST_START;
      end
      ST_START: begin
        eng_start = 1'b1;
        state_d   = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (eng_done) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        swap    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-port arbitration: the display always wins, the engine stalls.
  always_comb begin
    disp_grant = disp_req;
    eng_grant  = (state_q == ST_COMPUTE) && !disp_req && !reset;
    busy       = (state_q != ST_IDLE);
  end

  // Request capture, buffer flip, generation count and overrun flag.
  always_comb begin
    step_d    = step;
    step_rise = step && !step_q && !run;

    // One-deep request: a new request while one is pending is simply lost.
    // Leaving WAIT_VB consumes the request; WAIT_VB always has pending set,
    // so a coincident request there would be dropped anyway.
    pending_d = pending_q;
    if ((state_q == ST_WAIT_VB) && vblank) begin
      pending_d = 1'b0;
    end else if (gen_due || step_rise) begin
      pending_d = 1'b1;
    end

    buf_sel_d   = buf_sel_q;
    gen_count_d = gen_count_q;
    if (state_q == ST_SWAP) begin
      buf_sel_d   = ~buf_sel_q;
      gen_count_d = gen_count_q + GEN_W'(1);
    end

    // A new frame starting while the engine is still busy means the
    // generation did not fit in blanking; the flag is sticky until reset.
    err_overrun_d = err_overrun_q;
    if ((state_q == ST_COMPUTE) && frame_start) begin
      err_overrun_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= 1'b0;
      step_q        <= 1'b0;
      buf_sel_q     <= 1'b0;
      gen_count_q   <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      step_q        <= step_d;
      buf_sel_q     <= buf_sel_d;
      gen_count_q   <= gen_count_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign buf_sel     = buf_sel_q;
  assign gen_count   = gen_count_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: doc/gol_gen_scheduler.md
GOL_GEN_SCHEDULER -- requirements
Module: gol_gen_scheduler

Interface
REQ-001 Parameter FRAMES_PER_GEN, default 8: frames displayed per generation in run mode; legal range 1..255.
REQ-002 Parameter GEN_W, default 16: width of gen_count.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level; high = free-running generations.
REQ-006 step  in  1  level, edge-detected; rising edge = one generation request, honoured only when run=0.
REQ-007 frame_start  in  1  one-cycle pulse from VGA timing at the start of each frame.
REQ-008 vblank  in  1  high during vertical blanking.
REQ-009 disp_req  in  1  display reader requests the shared cell-RAM read port.
REQ-010 disp_grant  out  1  display owns the read port this cycle.
REQ-011 eng_start  out  1  one-cycle pulse that launches the update engine.
REQ-012 eng_grant  out  1  update engine owns the read port this cycle.
REQ-013 eng_done  in  1  one-cycle pulse from the engine when the generation has been written.
REQ-014 swap  out  1  one-cycle pulse when the double buffer flips.
REQ-015 buf_sel  out  1  buffer currently displayed; the engine writes buffer !buf_sel.
REQ-016 gen_count  out  GEN_W  completed generations.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err_overrun  out  1  sticky flag: a generation overran blanking.

Function
REQ-019 FSM states: IDLE, WAIT_VB, START, COMPUTE, SWAP.
- IDLE -> WAIT_VB when pending=1.
- WAIT_VB -> START when vblank=1.
- START -> COMPUTE unconditionally; eng_start=1 in START only.
- COMPUTE -> SWAP on eng_done=1; eng_done is ignored in every other state.
- SWAP -> IDLE; swap=1 in SWAP; buf_sel toggles and gen_count increments at exit.
- pending clears on entry to START.
REQ-020 Frame divider: while run=1, count frame_start pulses.
- When the count reaches FRAMES_PER_GEN-1 and frame_start=1, the count returns to 0 and pending is set.
- run=0 holds the count at 0.
REQ-021 A step rising edge (step=1 with step_q=0) while run=0 sets pending in any state.
REQ-022 pending is one deep: a due event while pending=1 is dropped without error.
- A due event while busy and pending=0 sets pending and is serviced after SWAP.
REQ-023 Arbitration, combinational:
- disp_grant = disp_req.
- eng_grant = (state==COMPUTE) && !disp_req.
- The display always has priority; the engine stalls while not granted.
REQ-024 frame_start=1 while in COMPUTE sets err_overrun; the computation continues to completion.
- err_overrun clears only on reset.
REQ-025 run falling mid-generation does not abort it; the in-progress generation completes.
REQ-026 gen_count wraps from 2^GEN_W-1 to 0.
REQ-027 Latency:
- vblank high in WAIT_VB -> eng_start on the next cycle.
- eng_done -> swap on the next cycle.
- buf_sel and gen_count update one cycle after swap.

Reset
REQ-028 While reset=1, the next edge forces:
- state=IDLE;
- pending, step_q, frame count, buf_sel, gen_count, err_overrun = 0;
- eng_start, swap, busy = 0.
REQ-029 Reset mid-COMPUTE abandons the generation: no swap, buf_sel unchanged from its reset value 0.
REQ-030 disp_grant follows disp_req even during reset; eng_grant=0 during reset.

Structure
REQ-031 Package gol_pkg holds:
- the state enum type gol_sched_state_t;
- the FRAMES_PER_GEN and GEN_W defaults.
REQ-032 The frame divider (REQ-020) is a sub-module, gol_frame_divider, that outputs a one-cycle gen_due pulse.

Verification
REQ-033 run=1, FRAMES_PER_GEN=8, vblank high 1 cycle after each frame_start, eng_done 5 cycles after eng_start, 16 frames -> exactly 2 eng_start pulses, gen_count=2, buf_sel=0.
REQ-034 run=0, step pulsed high then low 3 times, one per frame -> 3 generations; step held high 20 frames -> 1 generation.
REQ-035 In COMPUTE, disp_req=1 for 4 cycles -> eng_grant=0 and disp_grant=1 for those 4 cycles, then eng_grant=1 resumes.
REQ-036 eng_done withheld across the next frame_start -> err_overrun=1; it stays 1 after the later SWAP and clears only on reset.
REQ-037 reset asserted 2 cycles after eng_start -> state IDLE, gen_count=0, buf_sel=0; a later eng_done pulse is ignored with no swap.
REQ-038 GEN_W=4, 16 step generations -> gen_count wraps to 0; buf_sel=0.
